// File: rtl/reg_write_scoreboard_pkg.sv
// ============================================================================
// Module   : reg_write_scoreboard_pkg
// Brief    : Shared source codes, slot-field widths and helpers for the
//            register-write scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

package reg_write_scoreboard_pkg;

   typedef logic [1:0] src_t;

   localparam src_t SRC_NONE = 2'd0;
   localparam src_t SRC_EX   = 2'd1;
   localparam src_t SRC_MEM  = 2'd2;
   localparam src_t SRC_WB   = 2'd3;

   localparam int SLOT_VALID_W = 1;
   localparam int SLOT_LOAD_W  = 1;
   localparam int CNT_W        = 2;

   function automatic logic [CNT_W-1:0] popcount3(input logic a, input logic b, input logic c);
      return {1'b0, a} + {1'b0, b} + {1'b0, c};
   endfunction

endpackage

`default_nettype wire

// File: rtl/reg_write_scoreboard_sb_src_lookup.sv
// ============================================================================
// Module   : sb_src_lookup
// Brief    : Finds the nearest slot (EX > MEM > WB) writing a queried register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sb_src_lookup
   import reg_write_scoreboard_pkg::*;
#(
   parameter int IDX_W = 5
) (
   input  logic             ex_valid_i,
   input  logic [IDX_W-1:0] ex_rd_i,
   input  logic             mem_valid_i,
   input  logic [IDX_W-1:0] mem_rd_i,
   input  logic             wb_valid_i,
   input  logic [IDX_W-1:0] wb_rd_i,
   input  logic [IDX_W-1:0] q_i,
   output logic [1:0]       src_o
);

   always_comb begin
      src_o = SRC_NONE;
      // x0 is never a real producer, so its query always reports none
      if (q_i != '0) begin
         if (ex_valid_i && (ex_rd_i == q_i)) begin
            src_o = SRC_EX;
         end else if (mem_valid_i && (mem_rd_i == q_i)) begin
            src_o = SRC_MEM;
         end else if (wb_valid_i && (wb_rd_i == q_i)) begin
            src_o = SRC_WB;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/reg_write_scoreboard.sv
// ============================================================================
// Module   : reg_write_scoreboard
// Brief    : Tracks in-flight rd writes through EX/MEM/WB and answers
//            rs1/rs2 dependency queries. Optional macro: WB_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_write_scoreboard
   import reg_write_scoreboard_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int IDX_W    = 5
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                id_valid_i,
   input  logic [IDX_W-1:0]    id_rd_i,
   input  logic                id_reg_write_i,
   input  logic                id_mem_read_i,
   input  logic                id_bubble_i,
   input  logic                flush_i,
   input  logic [IDX_W-1:0]    q_rs1_i,
   input  logic [IDX_W-1:0]    q_rs2_i,
   output logic [1:0]          rs1_src_o,
   output logic [1:0]          rs2_src_o,
   output logic                load_use_o,
   output logic [NUM_REGS-1:0] busy_vec_o,
   output logic [CNT_W-1:0]    pending_cnt_o
);

   logic             ex_valid_q,  ex_valid_d;
   logic [IDX_W-1:0] ex_rd_q,     ex_rd_d;
   logic             ex_load_q,   ex_load_d;
   logic             mem_valid_q;
   logic [IDX_W-1:0] mem_rd_q;
   logic             mem_load_q;
   logic             wb_valid_q;
   logic [IDX_W-1:0] wb_rd_q;
   logic             wb_load_q;
   logic             wb_vis;

   always_comb begin
      ex_valid_d = id_valid_i & id_reg_write_i & (id_rd_i != '0) & ~id_bubble_i & ~flush_i;
      ex_rd_d    = ex_valid_d ? id_rd_i : '0;
      ex_load_d  = ex_valid_d & id_mem_read_i;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ex_valid_q  <= 1'b0;
         ex_rd_q     <= '0;
         ex_load_q   <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_rd_q    <= '0;
         mem_load_q  <= 1'b0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
         wb_load_q   <= 1'b0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_rd_q     <= ex_rd_d;
         ex_load_q   <= ex_load_d;
         mem_valid_q <= ex_valid_q;
         mem_rd_q    <= ex_rd_q;
         mem_load_q  <= ex_load_q;
         wb_valid_q  <= mem_valid_q;
         wb_rd_q     <= mem_rd_q;
         wb_load_q   <= mem_load_q;
      end
   end

   // With register-file write-through the WB slot is already resolved
`ifdef WB_BYPASS_EN
   assign wb_vis = 1'b0;
`else
   assign wb_vis = wb_valid_q;
`endif

   sb_src_lookup #(.IDX_W(IDX_W)) u_rs1_lookup (
      .ex_valid_i  (ex_valid_q),
      .ex_rd_i     (ex_rd_q),
      .mem_valid_i (mem_valid_q),
      .mem_rd_i    (mem_rd_q),
      .wb_valid_i  (wb_vis),
      .wb_rd_i     (wb_rd_q),
      .q_i         (q_rs1_i),
      .src_o       (rs1_src_o)
   );

   sb_src_lookup #(.IDX_W(IDX_W)) u_rs2_lookup (
      .ex_valid_i  (ex_valid_q),
      .ex_rd_i     (ex_rd_q),
      .mem_valid_i (mem_valid_q),
      .mem_rd_i    (mem_rd_q),
      .wb_valid_i  (wb_vis),
      .wb_rd_i     (wb_rd_q),
      .q_i         (q_rs2_i),
      .src_o       (rs2_src_o)
   );

   assign load_use_o = ex_valid_q & ex_load_q &
                       (((q_rs1_i != '0) && (q_rs1_i == ex_rd_q)) ||
                        ((q_rs2_i != '0) && (q_rs2_i == ex_rd_q)));

   assign busy_vec_o[0] = 1'b0;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_busy
      assign busy_vec_o[r] = (ex_valid_q  && (ex_rd_q  == IDX_W'(r))) ||
                             (mem_valid_q && (mem_rd_q == IDX_W'(r))) ||
                             (wb_vis      && (wb_rd_q  == IDX_W'(r)));
   end

   assign pending_cnt_o = popcount3(ex_valid_q, mem_valid_q, wb_vis);

   // The load flag only matters in EX; later copies just travel with the slot
   logic unused_load;
   assign unused_load = mem_load_q ^ wb_load_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_write_scoreboard.sv
// ============================================================================
// Module   : tb_reg_write_scoreboard
// Brief    : Directed self-checking bench for reg_write_scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reg_write_scoreboard;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid, id_reg_write, id_mem_read, id_bubble, flush;
   logic [4:0]  id_rd, q_rs1, q_rs2;
   logic [1:0]  rs1_src, rs2_src;
   logic        load_use;
   logic [31:0] busy_vec;
   logic [1:0]  pending_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_write_scoreboard #(.NUM_REGS(32), .IDX_W(5)) dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .id_valid_i     (id_valid),
      .id_rd_i        (id_rd),
      .id_reg_write_i (id_reg_write),
      .id_mem_read_i  (id_mem_read),
      .id_bubble_i    (id_bubble),
      .flush_i        (flush),
      .q_rs1_i        (q_rs1),
      .q_rs2_i        (q_rs2),
      .rs1_src_o      (rs1_src),
      .rs2_src_o      (rs2_src),
      .load_use_o     (load_use),
      .busy_vec_o     (busy_vec),
      .pending_cnt_o  (pending_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      id_valid = 1'b0; id_rd = 5'd0; id_reg_write = 1'b0;
      id_mem_read = 1'b0; id_bubble = 1'b0; flush = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic ld);
      id_valid = 1'b1; id_rd = rd; id_reg_write = 1'b1;
      id_mem_read = ld; id_bubble = 1'b0; flush = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; q_rs1 = 5'd0; q_rs2 = 5'd0;
      idle();
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_pending", 32'(pending_cnt), 32'd0);
      chk("rst_busy",    busy_vec,         32'd0);
      chk("rst_rs1",     32'(rs1_src),     32'd0);
      chk("rst_lu",      32'(load_use),    32'd0);

      // Shift timing of add x5
      issue(5'd5, 1'b0); q_rs1 = 5'd5;
      tick(); idle(); #1;
      chk("shift_t1_src",  32'(rs1_src),     32'd1);
      chk("shift_t1_busy", 32'(busy_vec[5]), 32'd1);
      chk("shift_t1_cnt",  32'(pending_cnt), 32'd1);
      tick();
      chk("shift_t2_src",  32'(rs1_src),     32'd2);
      chk("shift_t2_busy", 32'(busy_vec[5]), 32'd1);
      tick();
      chk("shift_t3_src",  32'(rs1_src),     BYP ? 32'd0 : 32'd3);
      chk("shift_t3_busy", 32'(busy_vec[5]), BYP ? 32'd0 : 32'd1);
      chk("shift_t3_cnt",  32'(pending_cnt), BYP ? 32'd0 : 32'd1);
      tick();
      chk("shift_t4_src",  32'(rs1_src),     32'd0);
      chk("shift_t4_busy", busy_vec,         32'd0);

      // Load-use, then one bubble
      do_reset(); q_rs1 = 5'd0;
      issue(5'd7, 1'b1);
      tick(); idle(); q_rs2 = 5'd7; #1;
      chk("lu_t1_lu",  32'(load_use), 32'd1);
      chk("lu_t1_src", 32'(rs2_src),  32'd1);
      issue(5'd8, 1'b0); id_bubble = 1'b1;
      tick(); idle(); #1;
      chk("lu_t2_src",  32'(rs2_src),     32'd2);
      chk("lu_t2_lu",   32'(load_use),    32'd0);
      chk("lu_t2_busy", busy_vec,         32'h0000_0080);
      chk("lu_t2_cnt",  32'(pending_cnt), 32'd1);

      // EX beats MEM beats WB
      do_reset(); q_rs2 = 5'd0;
      issue(5'd3, 1'b0);
      tick();
      issue(5'd3, 1'b0);
      tick(); idle(); q_rs1 = 5'd3; q_rs2 = 5'd3; #1;
      chk("prio_rs1", 32'(rs1_src),     32'd1);
      chk("prio_rs2", 32'(rs2_src),     32'd1);
      chk("prio_cnt", 32'(pending_cnt), 32'd2);
      chk("prio_busy", busy_vec,        32'h0000_0008);
      tick();
      chk("prio_mem_rs1", 32'(rs1_src),     32'd2);
      chk("prio_mem_cnt", 32'(pending_cnt), BYP ? 32'd1 : 32'd2);

      // Flush, x0 write, invalid ID and bubble+flush record nothing
      do_reset();
      issue(5'd9, 1'b0); flush = 1'b1;
      tick();
      issue(5'd0, 1'b0);
      tick();
      issue(5'd11, 1'b0); id_valid = 1'b0;
      tick();
      issue(5'd10, 1'b1); id_bubble = 1'b1; flush = 1'b1;
      tick(); idle(); q_rs1 = 5'd0; q_rs2 = 5'd9; #1;
      chk("x0_cnt",  32'(pending_cnt), 32'd0);
      chk("x0_rs1",  32'(rs1_src),     32'd0);
      chk("x0_rs2",  32'(rs2_src),     32'd0);
      chk("x0_busy", busy_vec,         32'd0);
      chk("x0_lu",   32'(load_use),    32'd0);

      // Full pipe, then reset mid-stream
      issue(5'd4, 1'b1);
      tick();
      issue(5'd6, 1'b0);
      tick();
      issue(5'd2, 1'b0);
      tick(); q_rs1 = 5'd4; q_rs2 = 5'd6; #1;
      chk("full_cnt",  32'(pending_cnt), BYP ? 32'd2 : 32'd3);
      chk("full_busy", busy_vec,         BYP ? 32'h0000_0044 : 32'h0000_0054);
      chk("full_rs1",  32'(rs1_src),     BYP ? 32'd0 : 32'd3);
      chk("full_rs2",  32'(rs2_src),     32'd2);
      reset = 1'b1;
      tick(); reset = 1'b0; idle(); #1;
      chk("mid_rst_cnt",  32'(pending_cnt), 32'd0);
      chk("mid_rst_busy", busy_vec,         32'd0);
      chk("mid_rst_rs1",  32'(rs1_src),     32'd0);
      chk("mid_rst_rs2",  32'(rs2_src),     32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
